// File: rtl/mult_product_accumulator.sv
// Product accumulator behind the 4x4 array multiplier. It sums a frame of
// COUNT_MAX unsigned 8-bit products into an ACC_W-bit accumulator. The sum
// wraps modulo 2^ACC_W. The result is then streamed out as two bytes, low
// byte first, over a valid/ready handshake.
module mult_product_accumulator #(
  parameter int ACC_W     = 16,  // 8..16
  parameter int COUNT_MAX = 8    // 1..15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] prod_in,
  input  logic       prod_valid,
  output logic       prod_ready,
  input  logic       clear,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] frame_cnt,
  output logic       overflow
);

  localparam int         SUM_W    = ACC_W + 1;
  localparam logic [3:0] CNT_LAST = 4'(COUNT_MAX);

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    SEND_LO = 2'd1,
    SEND_HI = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  // The extra top bit of the sum is the carry out of the accumulator.
  logic [SUM_W-1:0] sum;
  logic [15:0]      acc_ext;

  assign sum     = {1'b0, acc_q} + SUM_W'(prod_in);
  assign acc_ext = 16'(acc_q);

  // State register: all frame state is cleared by a synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments. All flops then
    // update together from values sampled before the edge.
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state logic. clear overrides any product accept or output handshake.
  always_comb begin
    // NOTE: every output of this block gets a default first. Without that,
    // a path that misses an assignment would infer a latch.
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (clear) begin
      state_d = ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (prod_valid) begin
            acc_d = sum[ACC_W-1:0];
            ovf_d = ovf_q | sum[ACC_W];
            cnt_d = cnt_q + 4'd1;
            if (cnt_q + 4'd1 == CNT_LAST) state_d = SEND_LO;
          end
        end
        SEND_LO: begin
          if (out_ready) state_d = SEND_HI;
        end
        SEND_HI: begin
          if (out_ready) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  // Output decode. Outputs come from registered state only, apart from clear -> prod_ready.
  always_comb begin
    prod_ready = (state_q == ACCUM) && !clear;
    out_valid  = (state_q == SEND_LO) || (state_q == SEND_HI);
    out_data   = 8'h00;
    unique case (state_q)
      SEND_LO: out_data = acc_ext[7:0];
      SEND_HI: out_data = acc_ext[15:8];
      default: out_data = 8'h00;
    endcase
  end

  assign frame_cnt = cnt_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_mult_product_accumulator.sv
// Directed bench for mult_product_accumulator. Three instances are used:
//   - the default build,
//   - an ACC_W=10 build that shares the default build's stimulus,
//   - a COUNT_MAX=1 build with its own stimulus.
module tb_mult_product_accumulator;

  logic clk = 1'b0;
  logic rst_n;

  // Shared stimulus for the default and ACC_W=10 instances.
  logic [7:0] prod_in;
  logic       prod_valid, clear, out_ready;
  logic       a_prod_ready, a_out_valid, a_ovf;
  logic [7:0] a_out_data;
  logic [3:0] a_cnt;
  logic       b_prod_ready, b_out_valid, b_ovf;
  logic [7:0] b_out_data;
  logic [3:0] b_cnt;

  // Stimulus for the COUNT_MAX=1 instance.
  logic [7:0] c_prod_in;
  logic       c_prod_valid, c_clear, c_out_ready;
  logic       c_prod_ready, c_out_valid, c_ovf;
  logic [7:0] c_out_data;
  logic [3:0] c_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult_product_accumulator dut (
    .clk(clk), .rst_n(rst_n), .prod_in(prod_in), .prod_valid(prod_valid),
    .prod_ready(a_prod_ready), .clear(clear), .out_data(a_out_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .frame_cnt(a_cnt),
    .overflow(a_ovf)
  );

  mult_product_accumulator #(.ACC_W(10)) dut_w10 (
    .clk(clk), .rst_n(rst_n), .prod_in(prod_in), .prod_valid(prod_valid),
    .prod_ready(b_prod_ready), .clear(clear), .out_data(b_out_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .frame_cnt(b_cnt),
    .overflow(b_ovf)
  );

  mult_product_accumulator #(.COUNT_MAX(1)) dut_c1 (
    .clk(clk), .rst_n(rst_n), .prod_in(c_prod_in), .prod_valid(c_prod_valid),
    .prod_ready(c_prod_ready), .clear(c_clear), .out_data(c_out_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .frame_cnt(c_cnt),
    .overflow(c_ovf)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs then change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  initial begin
    rst_n = 1'b0; prod_in = 8'h00; prod_valid = 1'b0; clear = 1'b0; out_ready = 1'b0;
    c_prod_in = 8'h00; c_prod_valid = 1'b0; c_clear = 1'b0; c_out_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    settle();

    // ---- Reset state
    check("rst_prod_ready", 16'(a_prod_ready), 16'd1);
    check("rst_out_valid",  16'(a_out_valid),  16'd0);
    check("rst_out_data",   16'(a_out_data),   16'h00);
    check("rst_frame_cnt",  16'(a_cnt),        16'd0);
    check("rst_overflow",   16'(a_ovf),        16'd0);
    check("rst_c1_ready",   16'(c_prod_ready), 16'd1);

    // ---- 8 x 0xE1 back to back, out_ready held high
    prod_in = 8'hE1; prod_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    prod_valid = 1'b0;
    settle();
    check("t1_lo_valid",    16'(a_out_valid), 16'd1);
    check("t1_lo_data",     16'(a_out_data),  16'h08);
    check("t1_lo_cnt",      16'(a_cnt),       16'd8);
    check("t1_lo_ovf",      16'(a_ovf),       16'd0);
    check("t1_lo_ready",    16'(a_prod_ready), 16'd0);
    check("w10_lo_data",    16'(b_out_data),  16'h08);
    check("w10_lo_ovf",     16'(b_ovf),       16'd1);
    tick();
    check("t1_hi_data",     16'(a_out_data),  16'h07);
    check("t1_hi_cnt",      16'(a_cnt),       16'd8);
    check("w10_hi_data",    16'(b_out_data),  16'h03);
    check("w10_hi_ovf",     16'(b_ovf),       16'd1);
    tick();
    check("t1_after_ready", 16'(a_prod_ready), 16'd1);
    check("t1_after_valid", 16'(a_out_valid), 16'd0);
    check("t1_after_cnt",   16'(a_cnt),       16'd0);
    check("w10_after_ovf",  16'(b_ovf),       16'd0);

    // ---- Products 1..8 with gaps, then a 5-cycle output stall
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      prod_valid = 1'b0;
      for (int g = 0; g < (i % 3); g++) tick();
      prod_in = 8'(i); prod_valid = 1'b1;
      settle();
      check("t3_acc_ready", 16'(a_prod_ready), 16'd1);
      tick();
    end
    // Keep offering a product during the stall; it must not be taken.
    prod_in = 8'h55; prod_valid = 1'b1;
    for (int s = 0; s < 5; s++) begin
      settle();
      check("t3_stall_valid", 16'(a_out_valid),  16'd1);
      check("t3_stall_data",  16'(a_out_data),   16'h24);
      check("t3_stall_ready", 16'(a_prod_ready), 16'd0);
      tick();
    end
    check("t3_stall_cnt", 16'(a_cnt), 16'd8);
    prod_valid = 1'b0; out_ready = 1'b1;
    settle();
    check("t3_lo_data",  16'(a_out_data),   16'h24);
    tick();
    check("t3_hi_data",  16'(a_out_data),   16'h00);
    check("t3_hi_ready", 16'(a_prod_ready), 16'd0);
    tick();
    check("t3_done_valid", 16'(a_out_valid), 16'd0);

    // ---- clear wins over a simultaneous product
    prod_in = 8'h10; prod_valid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("t4_cnt3", 16'(a_cnt), 16'd3);
    clear = 1'b1;
    settle();
    check("t4_clear_ready", 16'(a_prod_ready), 16'd0);
    tick();
    clear = 1'b0; prod_valid = 1'b0;
    settle();
    check("t4_clear_cnt",  16'(a_cnt),        16'd0);
    check("t4_clear_rdy",  16'(a_prod_ready), 16'd1);
    prod_in = 8'h01; prod_valid = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    prod_valid = 1'b0;
    settle();
    check("t4_lo_data", 16'(a_out_data), 16'h08);
    tick();
    check("t4_hi_data", 16'(a_out_data), 16'h00);
    tick();

    // ---- Reset while in SEND_LO
    out_ready = 1'b0; prod_in = 8'hE1; prod_valid = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    prod_valid = 1'b0;
    settle();
    check("t5_in_send_lo", 16'(a_out_valid), 16'd1);
    check("t5_w10_ovf",    16'(b_ovf),       16'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    settle();
    check("t5_valid", 16'(a_out_valid),  16'd0);
    check("t5_ready", 16'(a_prod_ready), 16'd1);
    check("t5_cnt",   16'(a_cnt),        16'd0);
    check("t5_ovf",   16'(b_ovf),        16'd0);

    // ---- COUNT_MAX=1: single product 0xFF
    c_prod_in = 8'hFF; c_prod_valid = 1'b1; c_out_ready = 1'b0;
    tick();
    c_prod_valid = 1'b0;
    settle();
    check("c1_valid", 16'(c_out_valid),  16'd1);
    check("c1_lo",    16'(c_out_data),   16'hFF);
    check("c1_cnt",   16'(c_cnt),        16'd1);
    check("c1_ready", 16'(c_prod_ready), 16'd0);
    c_out_ready = 1'b1;
    tick();
    check("c1_hi", 16'(c_out_data), 16'h00);
    tick();
    check("c1_done_valid", 16'(c_out_valid),  16'd0);
    check("c1_done_ready", 16'(c_prod_ready), 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
